vrased_mon: RTL and testbench
=============================

# vrased_mon

Parametrised successor to the single-configuration monitor top. It checks CPU data accesses, DMA accesses and trusted-code atomicity against `NUM_REGIONS` configurable protected regions. On any violation it drives one registered, held `reset` to the MCU. A cause/region capture register and a saturating violation counter record what happened. It sits between the openMSP430 core signals and the POR/PUC logic, in place of the per-monitor OR tree.

## Interface
- `NUM_REGIONS`, 4: number of protected regions (1..8).
- `REGION_BASE`, {16'h6A00,16'h0400,16'h0270,16'hE000}: packed 16b bases; region r is at `[16r+15:16r]`.
- `REGION_SIZE`, {16'h0040,16'h0C00,16'h0020,16'h2000}: packed 16b sizes; size 0 disables the region.
- `REGION_MODE`, {2'b11,2'b11,2'b11,2'b11}: per-region mode bits.
  - bit0: 1 = reads and writes protected; 0 = writes only.
  - bit1: 1 = DMA blocked.
- `SMEM_BASE`, 16'hA000: trusted code base.
- `SMEM_SIZE`, 16'h4000: trusted code size.
- `FST_ADDR`, 16'hA028: only legal trusted entry PC.
- `LST_ADDR`, 16'hA048: only legal trusted exit PC.
- `RESET_HANDLER`, 16'h0000: PC that releases `reset`.
- `HOLD_CYCLES`, 4: minimum cycles `reset` is held (≥1).
- `CNT_W`, 8: violation counter width.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low monitor reset.
- `pc` in 16: current PC.
- `data_en` in 1: CPU data access.
- `data_wr` in 1: CPU write.
- `data_addr` in 16: CPU data address.
- `dma_en` in 1: DMA access.
- `dma_addr` in 16: DMA address.
- `irq` in 1: interrupt taken.
- `reset` out 1: MCU reset request, registered.
- `viol_src` out 3: cause of the last violation.
- `viol_region` out `$clog2(NUM_REGIONS)` (min 1): region index of the last violation.
- `viol_cnt` out `CNT_W`: saturating violation count.

## Operation
**Region and trusted-code checks**
- in_region(a,r): `a >= base_r` and `{1'b0,a} < {1'b0,base_r}+size_r`. The upper bound is computed in 17 bits, so there is no wrap.
- in_smem(a): same test against `SMEM_BASE`/`SMEM_SIZE`.

**Violation conditions** (evaluated only in state RUN):
- ATOM_ENTRY (cause 1): `!in_smem(pc_prev) && in_smem(pc) && pc!=FST_ADDR`.
- ATOM_EXIT (cause 2): `in_smem(pc_prev) && !in_smem(pc) && pc_prev!=LST_ADDR`.
- IRQ (cause 3): `irq && in_smem(pc)`.
- CPU (cause 4): `data_en && in_region(data_addr,r) && !in_smem(pc) && (mode_r[0] || data_wr)`.
- DMA (cause 5): `dma_en && in_region(dma_addr,r) && mode_r[1]`.

**Priority and capture**
- Priority order: 1 > 2 > 3 > 4 > 5.
- Within CPU or within DMA, the lowest region index wins.
- `viol_region` = 0 for causes 1–3.

**FSM**
- RUN: on a violation, go to HOLD. Latch `viol_src`/`viol_region`, increment `viol_cnt` (saturates at all-ones), and load hold_ctr = `HOLD_CYCLES`-1.
- HOLD: hold_ctr decrements each cycle. When hold_ctr==0, go to WAIT.
- WAIT: when `pc==RESET_HANDLER`, go to RUN.
- `reset`=1 whenever the state is HOLD or WAIT.
- Violations in HOLD/WAIT are ignored: not counted, not captured.

**pc_prev register**
- Updated with `pc` every cycle in RUN.
- Forced to `RESET_HANDLER` in HOLD/WAIT, so the first RUN cycle never sees a spurious atomicity event.

**Capture lifetime**
- `viol_src`/`viol_region` are sticky until the next captured violation.
- `viol_cnt` clears only on `reset_n`.

## Timing
- Violation sampled at edge n: `reset`=1 from edge n+1. Latency is 1 cycle and all outputs are registered.
- `reset` stays high for at least `HOLD_CYCLES`+1 cycles: `HOLD_CYCLES` cycles in HOLD plus at least one in WAIT.
- `reset` drops on the edge after `pc==RESET_HANDLER` is sampled in WAIT.
- `reset_n` low, at any point including mid-HOLD:
  - next edge: state RUN, `reset`=0, `viol_src`=0, `viol_region`=0, `viol_cnt`=0, hold_ctr=0, pc_prev=`RESET_HANDLER`.
  - `reset_n` overrides every other input.
- Simultaneous CPU and DMA violations: only the higher-priority one is captured, and the count increments by 1.

## Structure
- Package `vrased_pkg`:
  - cause encoding constants (NONE=0 .. DMA=5);
  - FSM state enum {RUN, HOLD, WAIT};
  - `in_range` function (17b compare).
- Sub-module `vrased_region_chk`: one instance per region via generate. It takes base/size/mode plus both address buses and outputs `cpu_hit`/`dma_hit`. Priority encoding and the FSM live in `vrased_mon`.

## Test plan
- Default parameters, `pc`=16'h8000, `data_en`=1, `data_wr`=0, `data_addr`=16'h6A10 → next cycle `reset`=1, `viol_src`=4, `viol_region`=3, `viol_cnt`=1; `reset` held ≥5 cycles until `pc`=0.
- Same access with `pc`=16'hA100 (trusted) → no reset, `viol_cnt`=0.
- `pc` 16'h8000→16'hA030 → `viol_src`=1. `pc` 16'h8000→16'hA028 → no violation.
- `dma_en`=1, `dma_addr`=16'h0410, with a simultaneous CPU write to 16'h0270 from `pc`=16'h8000 → `viol_src`=4, `viol_region`=1, `viol_cnt` +1 only.
- 256 violations with `CNT_W`=8 → `viol_cnt` saturates at 8'hFF. A violation during WAIT leaves cause and count unchanged.
- `reset_n`=0 during HOLD → next edge `reset`=0 and all captures 0; `pc_prev` does not trigger ATOM_ENTRY when `pc`=16'hA028 next.

Source files
------------

// File: rtl/vrased_pkg.sv
// rtl/vrased_pkg.sv - shared cause codes, FSM states and range helper for vrased_mon
package vrased_pkg;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_ATOM_ENTRY = 3'd1;
    localparam logic [2:0] CAUSE_ATOM_EXIT  = 3'd2;
    localparam logic [2:0] CAUSE_IRQ        = 3'd3;
    localparam logic [2:0] CAUSE_CPU        = 3'd4;
    localparam logic [2:0] CAUSE_DMA        = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Upper bound is formed in 17 bits so a region ending at 16'hFFFF does not wrap.
    // A zero size makes the range empty.
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] base,
                                      input logic [15:0] size);
        logic [16:0] upper;
        upper = {1'b0, base} + {1'b0, size};
        return (a >= base) && ({1'b0, a} < upper);
    endfunction

endpackage

// File: rtl/vrased_region_chk.sv
// rtl/vrased_region_chk.sv - per-region CPU and DMA hit detection
module vrased_region_chk
    import vrased_pkg::*;
(
    input  logic [15:0] base,
    input  logic [15:0] size,
    input  logic [1:0]  mode,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic        dma_en,
    input  logic [15:0] dma_addr,
    output logic        cpu_hit,
    output logic        dma_hit
);

    // mode[0] clear leaves reads open, so only writes hit.
    assign cpu_hit = data_en && in_range(data_addr, base, size) && (mode[0] || data_wr);
    assign dma_hit = dma_en && in_range(dma_addr, base, size) && mode[1];

endmodule

// File: rtl/vrased_mon.sv
// rtl/vrased_mon.sv - multi-region access and atomicity monitor driving MCU reset
module vrased_mon
    import vrased_pkg::*;
#(
    parameter int                          NUM_REGIONS   = 4,
    parameter logic [16*NUM_REGIONS-1:0]   REGION_BASE   = {16'h6A00, 16'h0400, 16'h0270, 16'hE000},
    parameter logic [16*NUM_REGIONS-1:0]   REGION_SIZE   = {16'h0040, 16'h0C00, 16'h0020, 16'h2000},
    parameter logic [2*NUM_REGIONS-1:0]    REGION_MODE   = {2'b11, 2'b11, 2'b11, 2'b11},
    parameter logic [15:0]                 SMEM_BASE     = 16'hA000,
    parameter logic [15:0]                 SMEM_SIZE     = 16'h4000,
    parameter logic [15:0]                 FST_ADDR      = 16'hA028,
    parameter logic [15:0]                 LST_ADDR      = 16'hA048,
    parameter logic [15:0]                 RESET_HANDLER = 16'h0000,
    parameter int                          HOLD_CYCLES   = 4,
    parameter int                          CNT_W         = 8,
    localparam int                         RW            = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      pc,
    input  logic             data_en,
    input  logic             data_wr,
    input  logic [15:0]      data_addr,
    input  logic             dma_en,
    input  logic [15:0]      dma_addr,
    input  logic             irq,
    output logic             reset,
    output logic [2:0]       viol_src,
    output logic [RW-1:0]    viol_region,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t           state;
    logic [HW-1:0]    hold_ctr;
    logic [15:0]      pc_prev;

    logic [NUM_REGIONS-1:0] cpu_hit;
    logic [NUM_REGIONS-1:0] dma_hit;

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        vrased_region_chk u_chk (
            .base      (REGION_BASE[16*r +: 16]),
            .size      (REGION_SIZE[16*r +: 16]),
            .mode      (REGION_MODE[2*r +: 2]),
            .data_en   (data_en),
            .data_wr   (data_wr),
            .data_addr (data_addr),
            .dma_en    (dma_en),
            .dma_addr  (dma_addr),
            .cpu_hit   (cpu_hit[r]),
            .dma_hit   (dma_hit[r])
        );
    end

    logic pc_in_smem;
    logic prev_in_smem;
    logic atom_entry;
    logic atom_exit;
    logic irq_viol;

    assign pc_in_smem   = in_range(pc, SMEM_BASE, SMEM_SIZE);
    assign prev_in_smem = in_range(pc_prev, SMEM_BASE, SMEM_SIZE);
    assign atom_entry   = !prev_in_smem && pc_in_smem && (pc != FST_ADDR);
    assign atom_exit    = prev_in_smem && !pc_in_smem && (pc_prev != LST_ADDR);
    assign irq_viol     = irq && pc_in_smem;

    // Lowest region index wins: scan downwards so the last match kept is the smallest.
    logic          cpu_any;
    logic          dma_any;
    logic [RW-1:0] cpu_sel;
    logic [RW-1:0] dma_sel;

    always_comb begin
        cpu_any = 1'b0;
        dma_any = 1'b0;
        cpu_sel = '0;
        dma_sel = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (cpu_hit[r]) begin
                cpu_any = 1'b1;
                cpu_sel = RW'(r);
            end
            if (dma_hit[r]) begin
                dma_any = 1'b1;
                dma_sel = RW'(r);
            end
        end
    end

    logic [2:0]    cause;
    logic [RW-1:0] cause_region;

    always_comb begin
        cause        = CAUSE_NONE;
        cause_region = '0;
        if (atom_entry) begin
            cause = CAUSE_ATOM_ENTRY;
        end else if (atom_exit) begin
            cause = CAUSE_ATOM_EXIT;
        end else if (irq_viol) begin
            cause = CAUSE_IRQ;
        end else if (cpu_any && !pc_in_smem) begin
            cause        = CAUSE_CPU;
            cause_region = cpu_sel;
        end else if (dma_any) begin
            cause        = CAUSE_DMA;
            cause_region = dma_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            reset       <= 1'b0;
            viol_src    <= CAUSE_NONE;
            viol_region <= '0;
            viol_cnt    <= '0;
            hold_ctr    <= '0;
            pc_prev     <= RESET_HANDLER;
        end else begin
            case (state)
                ST_RUN: begin
                    pc_prev <= pc;
                    if (cause != CAUSE_NONE) begin
                        state       <= ST_HOLD;
                        reset       <= 1'b1;
                        viol_src    <= cause;
                        viol_region <= cause_region;
                        hold_ctr    <= HW'(HOLD_CYCLES - 1);
                        if (viol_cnt != {CNT_W{1'b1}}) begin
                            viol_cnt <= viol_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Forcing pc_prev keeps the first RUN cycle free of atomicity events.
                    pc_prev <= RESET_HANDLER;
                    if (hold_ctr == '0) begin
                        state <= ST_WAIT;
                    end else begin
                        hold_ctr <= hold_ctr - HW'(1);
                    end
                end
                ST_WAIT: begin
                    pc_prev <= RESET_HANDLER;
                    if (pc == RESET_HANDLER) begin
                        state <= ST_RUN;
                        reset <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vrased_mon.sv
// tb/tb_vrased_mon.sv - scoreboard bench for vrased_mon with directed vectors
module tb_vrased_mon;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;
    logic        reset;
    logic [2:0]  viol_src;
    logic [1:0]  viol_region;
    logic [7:0]  viol_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] src;
        logic [1:0] region;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_reset = 1'b0;

    logic [2:0] last_src    = 3'd0;
    logic [1:0] last_region = 2'd0;
    logic [7:0] last_cnt    = 8'd0;

    vrased_mon dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .data_en     (data_en),
        .data_wr     (data_wr),
        .data_addr   (data_addr),
        .dma_en      (dma_en),
        .dma_addr    (dma_addr),
        .irq         (irq),
        .reset       (reset),
        .viol_src    (viol_src),
        .viol_region (viol_region),
        .viol_cnt    (viol_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising edge of reset is one DUT response; pop and compare its capture.
    always @(negedge clk) begin
        if (reset === 1'b1 && prev_reset !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_reset", 16'(reset), 16'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("viol_src", 16'(viol_src), 16'(mon_e.src));
                check("viol_region", 16'(viol_region), 16'(mon_e.region));
                check("viol_cnt", 16'(viol_cnt), 16'(mon_e.cnt));
            end
        end
        prev_reset = reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc        = 16'h8000;
        data_en   = 1'b0;
        data_wr   = 1'b0;
        data_addr = 16'h0000;
        dma_en    = 1'b0;
        dma_addr  = 16'h0000;
        irq       = 1'b0;
    endtask

    task automatic expect_viol(input logic [2:0] src, input logic [1:0] rgn);
        if (last_cnt != 8'hFF) last_cnt = last_cnt + 8'd1;
        last_src    = src;
        last_region = rgn;
        exp_q.push_back('{src: src, region: rgn, cnt: last_cnt});
    endtask

    // Inputs for the violating cycle are set by the caller.
    task automatic run_violation(input logic [2:0] src, input logic [1:0] rgn, input bit wait_viol);
        expect_viol(src, rgn);
        step();
        idle();
        for (int i = 0; i <= HOLD; i++) begin
            check("reset_held", 16'(reset), 16'd1);
            if (i < HOLD) step();
        end
        if (wait_viol) begin
            data_en   = 1'b1;
            data_addr = 16'h6A10;
            step();
            check("wait_reset_held", 16'(reset), 16'd1);
            check("wait_src_kept", 16'(viol_src), 16'(last_src));
            check("wait_cnt_kept", 16'(viol_cnt), 16'(last_cnt));
            idle();
        end
        pc = 16'h0000;
        step();
        check("reset_release", 16'(reset), 16'd0);
        pc = 16'h8000;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        step();
        step();
        check("rst_reset", 16'(reset), 16'd0);
        check("rst_src", 16'(viol_src), 16'd0);
        check("rst_region", 16'(viol_region), 16'd0);
        check("rst_cnt", 16'(viol_cnt), 16'd0);
        reset_n = 1'b1;
        step();

        // Trusted code reading a protected region is allowed
        pc = 16'hA028; step();
        check("trusted_entry", 16'(reset), 16'd0);
        pc = 16'hA100; data_en = 1'b1; data_addr = 16'h6A10; step();
        check("trusted_access", 16'(reset), 16'd0);
        check("trusted_cnt", 16'(viol_cnt), 16'd0);
        idle(); pc = 16'hA048; step();
        pc = 16'h8000; step();
        check("trusted_exit", 16'(reset), 16'd0);

        // Untrusted CPU read of region 3
        data_en = 1'b1; data_addr = 16'h6A10;
        run_violation(3'd4, 2'd3, 1'b0);

        // Legal entry and exit
        pc = 16'hA028; step();
        check("legal_entry", 16'(reset), 16'd0);
        pc = 16'hA048; step();
        pc = 16'h8000; step();
        check("legal_exit", 16'(reset), 16'd0);

        // Illegal entry point
        pc = 16'hA030;
        run_violation(3'd1, 2'd0, 1'b0);

        // Simultaneous CPU write (region 1) and DMA (region 2): CPU wins
        data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0270;
        dma_en = 1'b1; dma_addr = 16'h0410;
        run_violation(3'd4, 2'd1, 1'b0);

        // DMA only, plus an ignored violation during WAIT
        dma_en = 1'b1; dma_addr = 16'h0410;
        run_violation(3'd5, 2'd2, 1'b1);

        // Interrupt inside trusted code
        pc = 16'hA028; irq = 1'b1;
        run_violation(3'd3, 2'd0, 1'b0);

        // Exit from a non-final address
        pc = 16'hA028; step();
        pc = 16'hA100; step();
        pc = 16'h8000;
        run_violation(3'd2, 2'd0, 1'b0);

        // Illegal entry beats simultaneous DMA violation
        pc = 16'hA030; dma_en = 1'b1; dma_addr = 16'h0410;
        run_violation(3'd1, 2'd0, 1'b0);

        // Region bounds: end address is exclusive; top of memory without wrap
        data_en = 1'b1; data_addr = 16'h6A40; step();
        check("bound_excl", 16'(reset), 16'd0);
        data_addr = 16'h026F; step();
        check("bound_below", 16'(reset), 16'd0);
        data_addr = 16'h6A3F;
        run_violation(3'd4, 2'd3, 1'b0);
        data_en = 1'b1; data_addr = 16'hFFFF;
        run_violation(3'd4, 2'd0, 1'b0);

        // reset_n during HOLD clears everything
        data_en = 1'b1; data_addr = 16'h6A10;
        expect_viol(3'd4, 2'd3);
        step();
        idle();
        step();
        step();
        reset_n = 1'b0;
        step();
        check("midhold_reset", 16'(reset), 16'd0);
        check("midhold_src", 16'(viol_src), 16'd0);
        check("midhold_region", 16'(viol_region), 16'd0);
        check("midhold_cnt", 16'(viol_cnt), 16'd0);
        reset_n = 1'b1;
        last_src = 3'd0; last_region = 2'd0; last_cnt = 8'd0;
        pc = 16'hA028; step();
        check("post_rst_entry", 16'(reset), 16'd0);
        pc = 16'hA048; step();
        pc = 16'h8000; step();
        check("post_rst_exit", 16'(reset), 16'd0);

        // Counter saturation
        for (int i = 0; i < 256; i++) begin
            data_en = 1'b1; data_addr = 16'h6A10;
            run_violation(3'd4, 2'd3, (i == 255));
        end
        check("sat_cnt", 16'(viol_cnt), 16'h00FF);

        step(); step(); step();
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
